mem_access_unit: RTL and testbench

//  Load/store unit in MEM stage; consumes controls/inst_size/is_signed bundle produced by ID.

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit. Takes the controls/inst_size/is_signed bundle
//   from ID and issues one data-memory transaction per load or store over a
//   req/gnt/rvalid bus. It stalls the pipeline while busy and returns
//   lane-extracted, sign- or zero-extended load data with a one-cycle done pulse.
//
//   Optional feature: define MEM_TIMEOUT_EN to enable a WAIT-state watchdog.
//   The watchdog ends the access with bus_err after TIMEOUT_CYCLES cycles
//   without rvalid. Without the macro, WAIT lasts until rvalid and bus_err is 0.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-low reset
//   issue_valid       MEM stage holds a valid instruction
//   controls[12:0]    {mem_read, mem_write, ...}; only bits 12:11 are used here
//   inst_size[1:0]    00 byte, 01 half, 10/11 word
//   is_signed         sign-extend loads when 1
//   addr, wdata       effective byte address, store data
//   stall             hold upstream stages
//   done              one-cycle completion pulse (also for faulted accesses)
//   load_data         extended load result, valid while done
//   misaligned        alignment fault, pulses with done
//   bus_err           timeout fault, pulses with done
//   mem_*             data-memory bus (req held until gnt, rvalid >= 1 cycle later)
//   state             FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
//
// Handshake: mem_req is held with stable mem_addr/we/wdata/wstrb until a cycle
// where mem_gnt=1; for loads, mem_rvalid is then accepted in a later cycle only.

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [12:0] controls,
    input  logic [1:0]  inst_size,
    input  logic        is_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        load_q;
    logic        fault_q;
    logic        bus_err_q;

    logic        mem_op;
    logic        misaligned_in;

    // A load wins when both mem_read and mem_write are set.
    assign mem_op        = issue_valid & (controls[12] | controls[11]);
    assign misaligned_in = ((inst_size == 2'b01) & addr[0]) |
                           (inst_size[1] & (addr[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    logic [TW-1:0] wait_cnt_q;
`else
    assign bus_err_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            load_q   <= 1'b0;
            fault_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_q  <= 1'b0;
            wait_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        size_q   <= inst_size;
                        signed_q <= is_signed;
                        load_q   <= controls[12];
                        fault_q  <= misaligned_in;
`ifdef MEM_TIMEOUT_EN
                        bus_err_q <= 1'b0;
`endif
                        state_q  <= misaligned_in ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state_q <= load_q ? S_WAIT : S_DONE;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state_q <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Counter holds the number of WAIT cycles already spent.
                    else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Store lane placement.
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = wdata_q;
        case (size_q)
            2'b00: begin
                wstrb_c = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << {addr_q[1], 1'b0};
                wdata_c = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension.
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] ext_c;
    assign sh_b = rdata_q >> {addr_q[1:0], 3'b000};
    assign sh_h = rdata_q >> {addr_q[1], 4'b0000};
    always_comb begin
        ext_c = rdata_q;
        case (size_q)
            2'b00: ext_c = {{24{signed_q & sh_b[7]}}, sh_b[7:0]};
            2'b01: ext_c = {{16{signed_q & sh_h[15]}}, sh_h[15:0]};
            default: ;
        endcase
    end

    logic in_req;
    assign in_req     = (state_q == S_REQ);
    assign done       = (state_q == S_DONE);
    assign misaligned = done & fault_q;
    assign bus_err    = done & bus_err_q;
    assign load_data  = (done & load_q & ~fault_q & ~bus_err_q) ? ext_c : 32'h0;
    assign stall      = ((state_q == S_IDLE) & mem_op) | in_req | (state_q == S_WAIT);
    assign mem_req    = in_req;
    assign mem_we     = in_req & ~load_q;
    assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (in_req & ~load_q) ? wdata_c : 32'h0;
    assign mem_wstrb  = (in_req & ~load_q) ? wstrb_c : 4'b0000;
    assign state      = state_q;

    logic unused_bits;
    assign unused_bits = ^{controls[10:0], sh_b[31:8], sh_h[31:16]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus a randomized mix,
// with expected load data kept in a queue and popped when done pulses.

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [12:0] controls;
    logic [1:0]  inst_size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .controls(controls),
        .inst_size(inst_size), .is_signed(is_signed), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .state(state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(logic [1:0] size, logic sgn,
                                               logic [31:0] a, logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00: return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01: return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic model_mis(logic [1:0] size, logic [31:0] a);
        if (size == 2'b01) return a[0];
        if (size[1])       return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(logic [1:0] size, logic [31:0] a);
        if (size == 2'b00) begin
            case (a[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (size == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] size, logic [31:0] wd);
        if (size == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (size == 2'b01) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic run_op(input logic ld, input logic st, input logic [1:0] size,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int gnt_dly, input logic rv_en,
                          output logic [31:0] got_data, output logic got_mis,
                          output logic got_berr, output int lat, output int stall_cyc,
                          output logic req_seen, output logic [3:0] strb_seen,
                          output logic [31:0] wdata_seen, output logic [31:0] addr_seen,
                          output logic we_seen);
        int   gcnt;
        logic rv_pending;
        gcnt = 0; rv_pending = 1'b0; lat = 0; stall_cyc = 0; req_seen = 1'b0;
        strb_seen = '0; wdata_seen = '0; addr_seen = '0; we_seen = 1'b0;
        got_data = '0; got_mis = 1'b0; got_berr = 1'b0;
        issue_valid = 1'b1;
        controls    = {ld, st, 11'($urandom)};
        inst_size   = size;
        is_signed   = sgn;
        addr        = a;
        wdata       = wd;
        forever begin
            #1;
            if (stall) stall_cyc++;
            if (done) begin
                got_data = load_data; got_mis = misaligned; got_berr = bus_err;
                break;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (rv_pending) begin
                mem_rvalid = rv_en; mem_rdata = rd; rv_pending = 1'b0;
            end
            if (mem_req) begin
                req_seen = 1'b1;
                if (gcnt >= gnt_dly) begin
                    strb_seen = mem_wstrb; wdata_seen = mem_wdata;
                    addr_seen = mem_addr;  we_seen = mem_we;
                    mem_gnt = 1'b1; rv_pending = ld;
                end
                gcnt++;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                // Inputs changing while stalled must have no effect.
                issue_valid = $urandom_range(0, 1);
                controls    = 13'($urandom);
                inst_size   = 2'($urandom);
                is_signed   = $urandom_range(0, 1);
                addr        = $urandom;
                wdata       = $urandom;
            end
            if (lat > 60) begin
                n_vec++; n_err++;
                $display("FAIL op_timeout: no done after %0d cycles, required done", lat);
                break;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; issue_valid = 1'b0; controls = '0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0; issue_valid = 1'b0; controls = '0; inst_size = '0; is_signed = 1'b0;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({stall, done, load_data, misaligned, bus_err, mem_req, mem_we, mem_addr,
             mem_wdata, mem_wstrb} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: stall=%b done=%b ld=%h mis=%b berr=%b req=%b we=%b addr=%h wd=%h strb=%b, required all 0",
                     stall, done, load_data, misaligned, bus_err, mem_req, mem_we,
                     mem_addr, mem_wdata, mem_wstrb);
        end
        n_vec++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL reset_state: got %0d required 0", state);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        logic [31:0] d, ws, as; logic m, be, rq, we; int lat, sc; logic [3:0] sb;
        exp_q.push_back(32'hDEADBEEF);
        run_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if (d !== exp_q[0]) begin
            n_err++; $display("FAIL lw_data: got %h required %h", d, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d required 3", lat); end
        n_vec++;
        if (sc !== 3) begin n_err++; $display("FAIL lw_stall_cycles: got %0d required 3", sc); end
        n_vec++;
        if ({as, we, sb} !== {32'h100, 1'b0, 4'b0000}) begin
            n_err++; $display("FAIL lw_bus: addr=%h we=%b strb=%b required 00000100/0/0000", as, we, sb);
        end
        n_vec++;
        if ({m, be} !== 2'b00) begin
            n_err++; $display("FAIL lw_flags: mis=%b berr=%b required 0/0", m, be);
        end
    endtask

    task automatic test_lb;
        logic [31:0] d, ws, as; logic m, be, rq, we; int lat, sc; logic [3:0] sb;
        exp_q.push_back(32'hFFFFFF80);
        run_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 1, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if (d !== exp_q[0]) begin
            n_err++; $display("FAIL lb_signed: got %h required %h", d, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(32'h00000080);
        run_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if (d !== exp_q[0]) begin
            n_err++; $display("FAIL lbu: got %h required %h", d, exp_q[0]);
        end
        void'(exp_q.pop_front());
        // mem_read and mem_write together behave as a load.
        exp_q.push_back(32'hFFFF8001);
        run_op(1, 1, 2'b01, 1, 32'h202, 32'h5555, 32'h8001_7777, 2, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if ({d, we} !== {exp_q[0], 1'b0}) begin
            n_err++; $display("FAIL both_set_is_load: data=%h we=%b required %h/0", d, we, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_store;
        logic [31:0] d, ws, as; logic m, be, rq, we; int lat, sc; logic [3:0] sb;
        exp_q.push_back(32'h0);
        run_op(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 0, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if ({sb, ws, we, as} !== {4'b1100, 32'hABCDABCD, 1'b1, 32'h100}) begin
            n_err++; $display("FAIL sh_bus: strb=%b wdata=%h we=%b addr=%h required 1100/abcdabcd/1/00000100",
                              sb, ws, we, as);
        end
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL sh_latency: got %0d required 2", lat); end
        n_vec++;
        if (d !== exp_q[0]) begin n_err++; $display("FAIL sh_load_data: got %h required %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
        run_op(0, 1, 2'b00, 0, 32'h301, 32'hCAFE00A5, 32'h0, 1, 1,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if ({sb, ws} !== {4'b0010, 32'hA5A5A5A5}) begin
            n_err++; $display("FAIL sb_bus: strb=%b wdata=%h required 0010/a5a5a5a5", sb, ws);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] d, ws, as; logic m, be, rq, we; int lat, sc; logic [3:0] sb;
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes = '{2'b10, 2'b01, 2'b11};
        addrs = '{32'h101, 32'h103, 32'h102};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0);
            run_op(1, 0, sizes[i], 1, addrs[i], 32'h0, 32'hFFFFFFFF, 0, 1,
                   d, m, be, lat, sc, rq, sb, ws, as, we);
            n_vec++;
            if ({m, rq, lat, d} !== {1'b1, 1'b0, 32'd1, exp_q[0]}) begin
                n_err++; $display("FAIL misaligned_%0d: mis=%b req_seen=%b lat=%0d data=%h required 1/0/1/%h",
                                  i, m, rq, lat, d, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_non_mem;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            controls = {2'b00, 11'($urandom)};
            addr = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if ({stall, mem_req, done, state} !== 5'b0) begin
                n_err++; $display("FAIL non_mem_%0d: stall=%b req=%b done=%b state=%0d required 0",
                                  i, stall, mem_req, done, state);
            end
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] d, ws, as, a, wd, rd; logic m, be, rq, we, ld, st, sgn, mis;
        int lat, sc, gd, kind, exp_lat; logic [3:0] sb; logic [1:0] sz;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            ld = (kind != 1); st = (kind != 0);
            sz = 2'($urandom); sgn = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = $urandom; rd = $urandom; gd = $urandom_range(0, 3);
            mis = model_mis(sz, a);
            exp_q.push_back((ld && !mis) ? model_load(sz, sgn, a, rd) : 32'h0);
            exp_lat = mis ? 1 : (ld ? gd + 3 : gd + 2);
            run_op(ld, st, sz, sgn, a, wd, rd, gd, 1, d, m, be, lat, sc, rq, sb, ws, as, we);
            n_vec++;
            if ({d, m, be, rq} !== {exp_q[0], mis, 1'b0, ~mis}) begin
                n_err++; $display("FAIL rand_%0d_result: data=%h mis=%b berr=%b req=%b required %h/%b/0/%b",
                                  i, d, m, be, rq, exp_q[0], mis, ~mis);
            end
            void'(exp_q.pop_front());
            n_vec++;
            if (lat !== exp_lat) begin
                n_err++; $display("FAIL rand_%0d_latency: got %0d required %0d", i, lat, exp_lat);
            end
            if (!ld && !mis) begin
                n_vec++;
                if ({sb, ws, we, as} !== {model_strb(sz, a), model_wdata(sz, wd), 1'b1, {a[31:2], 2'b00}}) begin
                    n_err++; $display("FAIL rand_%0d_store: strb=%b wdata=%h we=%b addr=%h required %b/%h/1/%h",
                                      i, sb, ws, we, as, model_strb(sz, a), model_wdata(sz, wd),
                                      {a[31:2], 2'b00});
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        issue_valid = 1'b1; controls = {2'b10, 11'h0}; inst_size = 2'b10;
        is_signed = 1'b0; addr = 32'h200;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_vec++;
        if ({mem_req, state} !== {1'b1, 2'd1}) begin
            n_err++; $display("FAIL mid_req_held: req=%b state=%0d required 1/1", mem_req, state);
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        n_vec++;
        if ({state, stall} !== {2'd2, 1'b1}) begin
            n_err++; $display("FAIL mid_in_wait: state=%0d stall=%b required 2/1", state, stall);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({stall, done, load_data, misaligned, bus_err, mem_req, mem_we, mem_addr,
             mem_wdata, mem_wstrb, state} !== '0) begin
            n_err++; $display("FAIL mid_reset_outputs: stall=%b done=%b req=%b state=%0d required all 0",
                              stall, done, mem_req, state);
        end
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({done, state, mem_req, load_data} !== '0) begin
            n_err++; $display("FAIL late_rvalid_ignored: done=%b state=%0d req=%b data=%h required 0",
                              done, state, mem_req, load_data);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d, ws, as; logic m, be, rq, we; int lat, sc; logic [3:0] sb;
        exp_q.push_back(32'h0);
        run_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'hFFFFFFFF, 0, 0,
               d, m, be, lat, sc, rq, sb, ws, as, we);
        n_vec++;
        if ({be, m, d, lat} !== {1'b1, 1'b0, exp_q[0], 32'd10}) begin
            n_err++; $display("FAIL timeout: berr=%b mis=%b data=%h lat=%0d required 1/0/%h/10",
                              be, m, d, lat, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask
`endif

    initial begin
        test_reset;
        test_lw;
        test_lb;
        test_store;
        test_misaligned;
        test_non_mem;
        test_random;
        test_reset_mid;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
